pipeline_hazard_controller: RTL and testbench
=============================================

# pipeline_hazard_controller

Central stall/flush sequencer for the five-stage integer pipeline. Takes hazard information from the ID, EX and MEM stages and generates the write enables and bubble/flush controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It covers four cases: load-use interlock, taken-branch flush, multicycle EX operations (divider/FPU), and data-memory wait states. It also keeps a saturating stall-cycle performance counter.

## Interface
- REG_ADDR_W, 5, register address width
- MC_CNT_W, 6, width of multicycle latency field and internal counter

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of instruction in ID
- id_use_rs1, id_use_rs2  in  1  instruction in ID actually reads rs1/rs2
- ex_rd  in  REG_ADDR_W  destination register of instruction in EX
- ex_load  in  1  instruction in EX is a load
- ex_branch_taken  in  1  EX resolved a taken branch/jump (PC target valid this cycle)
- ex_mc_start  in  1  EX issues a multicycle op this cycle
- ex_mc_cycles  in  MC_CNT_W  stall cycles N required by that op
- mem_req  in  1  MEM stage has an outstanding data access
- mem_ready  in  1  data memory completes the access this cycle
- pc_wren, if_id_wren, id_ex_wren, ex_mem_wren  out  1  register write enables
- if_id_flush  out  1  top level loads NOP (0) into IF/ID when asserted with if_id_wren
- id_ex_bubble, ex_mem_bubble  out  1  top level loads NOP into that register
- stall_state  out  2  0=RUN, 1=MC_WAIT, 2=MEM_WAIT
- stall_count  out  32  saturating count of cycles with pc_wren=0

## Operation
- Definitions:
  - load_use = ex_load && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
  - mem_stall = mem_req && !mem_ready.
- Defaults: all wren=1, flush/bubble=0.
- RUN, evaluated in this priority order:
  1. mem_stall: all four wren=0. Next state MEM_WAIT.
  2. ex_mc_start && N!=0: pc/if_id/id_ex wren=0, ex_mem_bubble=1. cnt<=N-1. Next state MC_WAIT if N>1, else RUN.
  3. ex_branch_taken: if_id_flush=1, id_ex_bubble=1. PC loads the target.
  4. load_use: pc_wren=0, if_id_wren=0, id_ex_bubble=1 (one-cycle bubble).
- ex_mc_start with N=0: no stall.
- Branch beats load_use, because the ID instruction is squashed anyway.
- MC_WAIT:
  - pc/if_id/id_ex wren=0, ex_mem_bubble=1.
  - Counter behaviour per cycle:
    - cnt==1: next RUN.
    - otherwise: cnt decrements.
  - If mem_stall also holds: ex_mem_wren=0, ex_mem_bubble=0, and cnt holds.
  - Branch, load_use and ex_mc_start are ignored; EX is frozen.
- MEM_WAIT:
  - While mem_stall: all four wren=0.
  - First cycle with mem_ready=1: apply the RUN rules (excluding mem_stall) combinationally, then next state RUN.
- stall_count increments on every cycle with pc_wren=0 and saturates at 0xFFFFFFFF.
- Total multicycle stall equals exactly N cycles, counting the start cycle.

## Timing
- Reset (reset_n low, asynchronous):
  - State RUN, cnt=0, stall_count=0.
  - Outputs forced to defaults (all wren=1, flush/bubble=0).
- All control outputs are combinational from current state and inputs. The consuming registers sample them at the same clk edge.
- State and counter update on rising clk.
- Deassertion of reset is synchronous to the design's first clk edge.
- Reset mid-MC_WAIT or mid-MEM_WAIT: return to RUN immediately, counter cleared.
- ex_mc_cycles is sampled only in the RUN start cycle. Later changes have no effect.
- Simultaneous mem_stall and ex_mc_start in RUN: mem_stall wins. ex_mc_start is re-evaluated on the mem_ready cycle.

## Structure
- Shared package (pipeline_pkg) holds:
  - stall_state encoding (RUN=0, MC_WAIT=1, MEM_WAIT=2)
  - NOP encoding (32'h0) used by flush/bubble muxes
  - REG_ADDR_W
- Sub-module: hazard_detect, purely combinational load_use and branch-priority logic.
- The FSM, counter and stall_count stay in the top of this block.

## Test plan
- Load-use: EX ex_load=1, ex_rd=5; ID id_use_rs2=1, id_rs2=5 -> one cycle with pc_wren=0, if_id_wren=0, id_ex_bubble=1; next cycle defaults; stall_count=1.
- Load to x0: ex_rd=0, id_rs1=0 -> no stall.
- Taken branch coincident with load_use -> if_id_flush=1, id_ex_bubble=1, pc_wren=1; no freeze.
- Multicycle, N=4 -> pc_wren=0 for exactly 4 cycles, ex_mem_bubble=1 in each; stall_state 0,1,1,1 then 0.
- Multicycle, N=1 -> single stall cycle, state never leaves RUN.
- MC_WAIT with 2-cycle mem_stall injected at N=5 -> stall extends to 7 cycles; ex_mem_wren=0 during the mem stall.
- mem_req=1, mem_ready low 3 cycles -> all wren=0 for 3 cycles, state MEM_WAIT.
- mem_req=1, mem_ready rises with ex_branch_taken=1 -> that cycle if_id_flush=1, state RUN.
- reset_n asserted while in MC_WAIT with cnt=3 -> immediately state RUN, all wren=1, stall_count=0.
- stall_count preloaded near 0xFFFFFFFF by forcing -> saturates at 0xFFFFFFFF, no wrap.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the integer pipeline: stall-state encoding, NOP word and
// register address width.
package pipeline_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [31:0] NOP        = 32'h0;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMcWait  = 2'd1,
    StMemWait = 2'd2
  } stall_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detection and branch-over-interlock priority.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_load,
  input  logic                  ex_branch_taken,
  output logic                  flush_req,
  output logic                  interlock_req
);

  logic load_use;

  always_comb begin
    load_use = ex_load && (ex_rd != '0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    flush_req     = ex_branch_taken;
    // A taken branch squashes the ID instruction, so its interlock is moot.
    interlock_req = load_use && !ex_branch_taken;
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, branch flush, multicycle EX
// and data-memory wait handling, plus a saturating stall-cycle counter.
module pipeline_hazard_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned MC_CNT_W = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_load,
  input  logic                  ex_branch_taken,
  input  logic                  ex_mc_start,
  input  logic [MC_CNT_W-1:0]   ex_mc_cycles,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_wren,
  output logic                  if_id_wren,
  output logic                  id_ex_wren,
  output logic                  ex_mem_wren,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_bubble,
  output logic [1:0]            stall_state,
  output logic [31:0]           stall_count
);

  stall_state_e        state_q, state_d;
  logic [MC_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]         stall_count_q;
  logic                mem_stall;
  logic                flush_req;
  logic                interlock_req;

  hazard_detect u_hazard_detect (
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_rd           (ex_rd),
    .ex_load         (ex_load),
    .ex_branch_taken (ex_branch_taken),
    .flush_req       (flush_req),
    .interlock_req   (interlock_req)
  );

  assign mem_stall = mem_req && !mem_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_wren       = 1'b1;
    if_id_wren    = 1'b1;
    id_ex_wren    = 1'b1;
    ex_mem_wren   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    // Outputs stay at defaults while reset is held.
    if (reset_n) begin
      case (state_q)
        StMcWait: begin
          pc_wren    = 1'b0;
          if_id_wren = 1'b0;
          id_ex_wren = 1'b0;
          if (mem_stall) begin
            ex_mem_wren = 1'b0;
          end else begin
            ex_mem_bubble = 1'b1;
            if (cnt_q == MC_CNT_W'(1)) begin
              state_d = StRun;
            end
            cnt_d = cnt_q - MC_CNT_W'(1);
          end
        end
        default: begin
          if (mem_stall) begin
            pc_wren     = 1'b0;
            if_id_wren  = 1'b0;
            id_ex_wren  = 1'b0;
            ex_mem_wren = 1'b0;
            state_d     = StMemWait;
          end else begin
            state_d = StRun;
            if (ex_mc_start && (ex_mc_cycles != '0)) begin
              pc_wren       = 1'b0;
              if_id_wren    = 1'b0;
              id_ex_wren    = 1'b0;
              ex_mem_bubble = 1'b1;
              cnt_d         = ex_mc_cycles - MC_CNT_W'(1);
              if (ex_mc_cycles > MC_CNT_W'(1)) begin
                state_d = StMcWait;
              end
            end else if (flush_req) begin
              if_id_flush  = 1'b1;
              id_ex_bubble = 1'b1;
            end else if (interlock_req) begin
              pc_wren      = 1'b0;
              if_id_wren   = 1'b0;
              id_ex_bubble = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StRun;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_wren && (stall_count_q != '1)) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  assign stall_state = state_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: directed hazard scenarios plus randomized traffic against a
// behavioural model of remaining stall cycles.
module tb_pipeline_hazard_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_load, ex_branch_taken, ex_mc_start;
  logic [5:0]  ex_mc_cycles;
  logic        mem_req, mem_ready;
  logic        pc_wren, if_id_wren, id_ex_wren, ex_mem_wren;
  logic        if_id_flush, id_ex_bubble, ex_mem_bubble;
  logic [1:0]  stall_state;
  logic [31:0] stall_count;

  int errors = 0;
  int checks = 0;

  // Model: cycles of multicycle stall still owed after this one, and memory-wait flag.
  int              mc_left = 0;
  bit              in_mem = 1'b0;
  longint unsigned m_count = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_rd           (ex_rd),
    .ex_load         (ex_load),
    .ex_branch_taken (ex_branch_taken),
    .ex_mc_start     (ex_mc_start),
    .ex_mc_cycles    (ex_mc_cycles),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_wren         (pc_wren),
    .if_id_wren      (if_id_wren),
    .id_ex_wren      (id_ex_wren),
    .ex_mem_wren     (ex_mem_wren),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_bubble   (ex_mem_bubble),
    .stall_state     (stall_state),
    .stall_count     (stall_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Compare process: expected outputs from the hazard rules and the model state.
  always @(negedge clk) begin : model_cmp
    logic [6:0] e_ctrl;
    int         e_st;
    bit         ms, lu, e_pc;
    if (!reset_n) begin
      mc_left = 0;
      in_mem  = 1'b0;
      m_count = 0;
    end
    chk("stall_count", stall_count, m_count[31:0]);
    ms = mem_req && !mem_ready;
    lu = ex_load && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    e_st = (mc_left > 0) ? 1 : (in_mem ? 2 : 0);
    // {pc, if_id, id_ex, ex_mem wren, if_id_flush, id_ex_bubble, ex_mem_bubble}
    e_ctrl = 7'b1111_000;
    if (!reset_n) begin
      e_st = 0;
    end else if (mc_left > 0) begin
      if (ms) begin
        e_ctrl = 7'b0000_000;
      end else begin
        e_ctrl = 7'b0001_001;
        mc_left--;
      end
    end else if (ms) begin
      e_ctrl = 7'b0000_000;
      in_mem = 1'b1;
    end else begin
      in_mem = 1'b0;
      if (ex_mc_start && ex_mc_cycles != 0) begin
        e_ctrl  = 7'b0001_001;
        mc_left = int'(ex_mc_cycles) - 1;
      end else if (ex_branch_taken) begin
        e_ctrl = 7'b1111_110;
      end else if (lu) begin
        e_ctrl = 7'b0011_010;
      end
    end
    chk("ctrl", {25'd0, pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, if_id_flush,
                 id_ex_bubble, ex_mem_bubble}, {25'd0, e_ctrl});
    chk("stall_state", {30'd0, stall_state}, e_st);
    e_pc = e_ctrl[6];
    if (reset_n && !e_pc && m_count < 64'hFFFF_FFFF) m_count++;
  end

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_load = 0; ex_branch_taken = 0;
    ex_mc_start = 0; ex_mc_cycles = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nstall;
    idle();
    cyc();
    @(negedge clk);
    chk("reset_pc_wren", {31'd0, pc_wren}, 32'd1);
    chk("reset_state", {30'd0, stall_state}, 32'd0);
    cyc();
    reset_n = 1'b1;
    cyc();

    // Load-use on rs2
    ex_load = 1; ex_rd = 5; id_use_rs2 = 1; id_rs2 = 5;
    @(negedge clk);
    chk("lu_ctrl", {29'd0, pc_wren, if_id_wren, id_ex_bubble}, 32'b001);
    cyc(); idle();
    @(negedge clk);
    chk("lu_after_pc", {31'd0, pc_wren}, 32'd1);
    chk("lu_count", stall_count, 32'd1);
    cyc();

    // Load to x0
    ex_load = 1; ex_rd = 0; id_use_rs1 = 1; id_rs1 = 0;
    @(negedge clk);
    chk("x0_pc_wren", {31'd0, pc_wren}, 32'd1);
    cyc();

    // Branch coincident with load-use
    ex_load = 1; ex_rd = 7; id_use_rs1 = 1; id_rs1 = 7; ex_branch_taken = 1;
    @(negedge clk);
    chk("br_lu", {29'd0, if_id_flush, id_ex_bubble, pc_wren}, 32'b111);
    chk("br_lu_ifid", {31'd0, if_id_wren}, 32'd1);
    cyc(); idle();

    // Multicycle N=4; later cycle-field changes must be ignored
    for (int i = 0; i < 5; i++) begin
      ex_mc_start = (i == 0);
      ex_mc_cycles = (i == 0) ? 6'd4 : 6'd9;
      @(negedge clk);
      chk("mc4_pc", {31'd0, pc_wren}, (i < 4) ? 32'd0 : 32'd1);
      chk("mc4_bub", {31'd0, ex_mem_bubble}, (i < 4) ? 32'd1 : 32'd0);
      chk("mc4_state", {30'd0, stall_state}, (i == 1 || i == 2 || i == 3) ? 32'd1 : 32'd0);
      cyc();
    end
    idle();

    // Multicycle N=1
    ex_mc_start = 1; ex_mc_cycles = 1;
    @(negedge clk);
    chk("mc1_pc", {31'd0, pc_wren}, 32'd0);
    cyc(); idle();
    @(negedge clk);
    chk("mc1_state", {30'd0, stall_state}, 32'd0);
    chk("mc1_pc_after", {31'd0, pc_wren}, 32'd1);
    cyc();

    // N=5 with two mem-stall cycles inside MC_WAIT
    nstall = 0;
    for (int i = 0; i < 10; i++) begin
      ex_mc_start = (i == 0);
      ex_mc_cycles = 5;
      mem_req = (i == 2 || i == 3);
      mem_ready = 0;
      @(negedge clk);
      if (!pc_wren) nstall++;
      chk("mc5_exmem_wren", {31'd0, ex_mem_wren}, (i == 2 || i == 3) ? 32'd0 : 32'd1);
      cyc();
    end
    chk("mc5_total", nstall, 32'd7);
    idle();

    // Memory wait 3 cycles, then ready with a taken branch
    for (int i = 0; i < 5; i++) begin
      mem_req = (i < 4); mem_ready = (i == 3); ex_branch_taken = (i == 3);
      @(negedge clk);
      if (i < 3) chk("mw_wren", {28'd0, pc_wren, if_id_wren, id_ex_wren, ex_mem_wren}, 32'd0);
      if (i == 1 || i == 2) chk("mw_state", {30'd0, stall_state}, 32'd2);
      if (i == 3) chk("mw_flush", {31'd0, if_id_flush}, 32'd1);
      if (i == 4) chk("mw_run", {30'd0, stall_state}, 32'd0);
      cyc();
    end
    idle();

    // Reset during MC_WAIT with cnt=3
    ex_mc_start = 1; ex_mc_cycles = 5;
    cyc(); idle();
    cyc();
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mc_state", {30'd0, stall_state}, 32'd0);
    chk("rst_mc_pc", {31'd0, pc_wren}, 32'd1);
    chk("rst_mc_count", stall_count, 32'd0);
    cyc();
    reset_n = 1'b1;
    cyc();

    // Saturation
    force dut.stall_count_q = 32'hFFFF_FFFD;
    m_count = 64'hFFFF_FFFD;
    @(negedge clk);
    #1 release dut.stall_count_q;
    cyc();
    ex_mc_start = 1; ex_mc_cycles = 4;
    cyc(); idle();
    repeat (4) cyc();
    @(negedge clk);
    chk("sat_count", stall_count, 32'hFFFF_FFFF);
    cyc();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom_range(0, 1));
      id_use_rs2 = 1'($urandom_range(0, 1));
      ex_load = ($urandom_range(0, 9) < 4);
      ex_branch_taken = ($urandom_range(0, 9) < 2);
      ex_mc_start = ($urandom_range(0, 9) < 1);
      ex_mc_cycles = 6'($urandom_range(0, 7));
      mem_req = ($urandom_range(0, 9) < 3);
      mem_ready = 1'($urandom_range(0, 1));
      reset_n = ($urandom_range(0, 299) != 0);
      cyc();
    end
    reset_n = 1'b1;
    idle();
    cyc();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
